muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Multiply/divide unit and HI/LO register file for the MIPS execute stage, sitting directly downstream of the integer ALU. It executes MULT/MULTU in a fixed 2-cycle latency and DIV/DIVU with a radix-2 restoring divider. It writes MTHI/MTLO data, which is the ALU result passed through, into HI/LO. It holds `busy` so the pipeline stalls, and it supports flush on exception.

## Interface
- WIDTH, 32, operand/HI/LO width; divider iteration count equals WIDTH
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  operation request this cycle
- func  in  6  MIPS function code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are ignored
- A  in  WIDTH  rs operand (dividend / multiplicand)
- B  in  WIDTH  rt operand (divisor / multiplier)
- alu_res  in  WIDTH  ALU result; source for MTHI/MTLO
- flush  in  1  cancel in-flight operation (exception/ERET)
- busy  out  1  operation in flight; upstream must hold the request
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- FSM states: IDLE, MUL, DIV, FIX. `busy` = (state != IDLE).
- Accept occurs when `req_valid & ~busy & ~flush`. Requests made while busy are ignored and are not queued.
- MTHI/MTLO on accept: `hi` or `lo` takes `alu_res` at that edge. State stays IDLE and `done` is not raised.
- MULT/MULTU on accept: register A, B, and signedness, then go to MUL. In MUL, form the 2·WIDTH product (signed or unsigned), write {hi, lo}, then go to IDLE.
- DIV/DIVU on accept:
  - Register |A| and |B| (magnitudes only for DIV; raw values for DIVU).
  - Record quotient sign = A[31]^B[31] and remainder sign = A[31] (DIV only).
  - Clear the iteration counter and go to DIV.
- DIV state: one restoring step per cycle for WIDTH cycles. Shift remainder:dividend left, trial-subtract the divisor, and set the quotient bit when the result is non-negative. After the last step, go to FIX.
- FIX state: apply sign corrections, write lo = quotient and hi = remainder, then go to IDLE.
- Divide by zero (B == 0): the result is hi = A (raw) and lo = all-ones. Sign fix is bypassed. Latency is unchanged and no exception is raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 and hi = 0. This falls out naturally from the magnitude arithmetic.
- Flush in any non-IDLE state: go to IDLE at the next edge. HI/LO are unchanged and `done` is not pulsed. Flush while IDLE has no effect.
- Reset: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, and all internal registers are cleared.

## Timing
- Cycle 0 is the accept cycle.
- MTHI/MTLO: the new value is visible on `hi`/`lo` from cycle 1.
- MULT/MULTU:
  - `busy` is high in cycle 1.
  - HI/LO are written at the end of cycle 1.
  - In cycle 2, `done` = 1, `busy` = 0, and the new values are visible.
- DIV/DIVU:
  - `busy` is high in cycles 1..WIDTH+1 (DIV steps in 1..WIDTH, FIX in WIDTH+1).
  - `done` is high and the new values are visible in cycle WIDTH+2, which is 34 for WIDTH=32.
- A new request may be accepted in the same cycle that `done` is high.
- `hi`/`lo` are register outputs with no combinational path from the inputs.
- If flush is asserted in cycle k while busy, `busy` = 0 in cycle k+1.

## Structure
- The shared header already holds the func-code macros. Add the MULT, MULTU, DIV, and DIVU codes there alongside the existing MTHI and MTLO codes.
- The state encoding is held as module-local constants.
- One sub-module, `div_radix2_step`, is combinational: it takes the partial remainder, dividend bit, and divisor, and returns the next remainder and the quotient bit. It is instantiated once in the DIV state datapath.
- The multiply is a single behavioural product expression.

## Test plan
- MULT A=0xFFFFFFFF, B=2 → cycle 2: hi=0xFFFFFFFF, lo=0xFFFFFFFE, done=1. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy in cycles 1..33, cycle 34: lo=0xFFFFFFFD, hi=0xFFFFFFFF, done=1. DIVU with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- DIV A=5, B=0 → cycle 34: hi=0x00000005, lo=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- Flush in cycle 10 of a DIV with prior hi=0x11, lo=0x22 → busy=0 in cycle 11, hi/lo unchanged, no done. A MULT request presented with flush=1 is not accepted.
- MTHI alu_res=0x1234 when idle → hi=0x1234 in cycle 1, done=0. MTLO presented while busy is ignored and lo is unchanged.
- Assert rst asynchronously mid-DIV → busy, done, hi, and lo go to 0 immediately. After release, MULT A=3, B=4 → lo=12, hi=0 in cycle 2.

Source files
------------

// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the MIPS SPECIAL function codes handled by the unit. It also holds
// the decoded-operation type and the decoder that turns a function code into
// an operation class plus a signedness flag.
package muldiv_hilo_pkg;

    localparam int FUNC_W = 6;

    localparam logic [FUNC_W-1:0] FUNC_MTHI  = 6'h11;
    localparam logic [FUNC_W-1:0] FUNC_MTLO  = 6'h13;
    localparam logic [FUNC_W-1:0] FUNC_MULT  = 6'h18;
    localparam logic [FUNC_W-1:0] FUNC_MULTU = 6'h19;
    localparam logic [FUNC_W-1:0] FUNC_DIV   = 6'h1A;
    localparam logic [FUNC_W-1:0] FUNC_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL,
        OP_DIV,
        OP_MTHI,
        OP_MTLO
    } op_kind_e;

    typedef struct packed {
        op_kind_e kind;
        logic     isSigned;
    } op_dec_t;

    // Function codes that this unit does not own decode to OP_NONE, so they are ignored.
    function automatic op_dec_t decodeFunc(input logic [FUNC_W-1:0] func);
        op_dec_t d;
        d.kind     = OP_NONE;
        d.isSigned = 1'b0;
        case (func)
            FUNC_MULT:  begin d.kind = OP_MUL;  d.isSigned = 1'b1; end
            FUNC_MULTU: begin d.kind = OP_MUL;  d.isSigned = 1'b0; end
            FUNC_DIV:   begin d.kind = OP_DIV;  d.isSigned = 1'b1; end
            FUNC_DIVU:  begin d.kind = OP_DIV;  d.isSigned = 1'b0; end
            FUNC_MTHI:  d.kind = OP_MTHI;
            FUNC_MTLO:  d.kind = OP_MTLO;
            default:    d.kind = OP_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Request/response bundle between the execute stage and the HI/LO unit.
//   req_valid, func, A, B, alu_res, flush : from pipeline to unit
//   busy, done, hi, lo                    : from unit to pipeline
// The master modport is the pipeline side. The slave modport is the unit side.
interface muldiv_hilo_if
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              req_valid;
    logic [FUNC_W-1:0] func;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [WIDTH-1:0]  alu_res;
    logic              flush;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output req_valid, func, A, B, alu_res, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  req_valid, func, A, B, alu_res, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_div_radix2_step.sv
// One restoring-division step, purely combinational.
//   remainder_i   : partial remainder, always smaller than the divisor
//   dividendBit_i : next dividend bit shifted into the remainder
//   divisor_i     : divisor magnitude
//   remainder_o   : partial remainder after the trial subtract
//   quotientBit_o : 1 when the trial subtract did not go negative
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remainder_i,
    input  logic             dividendBit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] remainder_o,
    output logic             quotientBit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit holds the shifted-out MSB. Because the remainder is below the
    // divisor, a non-negative difference always fits back into WIDTH bits.
    assign shifted       = {remainder_i, dividendBit_i};
    assign diff          = shifted - {1'b0, divisor_i};
    assign quotientBit_o = ~diff[WIDTH];
    assign remainder_o   = quotientBit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/muldiv_hilo.sv
// MIPS multiply/divide unit with HI/LO registers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of muldiv_hilo_if (request in; busy/done/hi/lo out)
// MULT/MULTU finish in 2 cycles. DIV/DIVU use a radix-2 restoring divider,
// with WIDTH steps and then one sign-fix cycle. MTHI/MTLO write alu_res
// directly. busy stalls the pipeline, and flush abandons the in-flight
// operation without touching HI/LO.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_hilo_if.slave     bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] opA_q,     opA_d;
    logic [WIDTH-1:0] opB_q,     opB_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             signed_q,  signed_d;
    logic             qNeg_q,    qNeg_d;
    logic             rNeg_q,    rNeg_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic             done_q,    done_d;

    logic             busy;
    logic             accept;
    op_dec_t          dec;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [2*WIDTH-1:0] mulA;
    logic [2*WIDTH-1:0] mulB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] stepRem;
    logic             stepQBit;

    assign busy   = (state_q != ST_IDLE);
    assign accept = bus.req_valid & ~busy & ~bus.flush;
    assign dec    = decodeFunc(bus.func);

    // Signed divides run on magnitudes; the signs are restored in the FIX state.
    assign magA = (dec.isSigned & bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign magB = (dec.isSigned & bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Sign- or zero-extend the operands to the full product width. The low 2*WIDTH
    // bits of the product are then right for both MULT and MULTU.
    assign mulA    = {{WIDTH{signed_q & opA_q[WIDTH-1]}}, opA_q};
    assign mulB    = {{WIDTH{signed_q & opB_q[WIDTH-1]}}, opB_q};
    assign product = mulA * mulB;

    // opA_q is the shifting dividend/quotient register. Each step consumes its MSB
    // and shifts the new quotient bit in at the LSB.
    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .remainder_i   (rem_q),
        .dividendBit_i (opA_q[WIDTH-1]),
        .divisor_i     (opB_q),
        .remainder_o   (stepRem),
        .quotientBit_o (stepQBit)
    );

    // Next-state logic. On divide-by-zero the restoring loop leaves |A| in the
    // remainder. Re-applying the dividend sign therefore gives back raw A, and
    // only the quotient needs the all-ones override.
    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        qNeg_d    = qNeg_q;
        rNeg_d    = rNeg_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (dec.kind)
                        OP_MTHI: hi_d = bus.alu_res;
                        OP_MTLO: lo_d = bus.alu_res;
                        OP_MUL: begin
                            opA_d    = bus.A;
                            opB_d    = bus.B;
                            signed_d = dec.isSigned;
                            state_d  = ST_MUL;
                        end
                        OP_DIV: begin
                            opA_d     = magA;
                            opB_d     = magB;
                            signed_d  = dec.isSigned;
                            qNeg_d    = dec.isSigned & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            rNeg_d    = dec.isSigned & bus.A[WIDTH-1];
                            divZero_d = (bus.B == '0);
                            rem_d     = '0;
                            cnt_d     = '0;
                            state_d   = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    hi_d   = product[2*WIDTH-1:WIDTH];
                    lo_d   = product[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = stepRem;
                    opA_d = {opA_q[WIDTH-2:0], stepQBit};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    hi_d   = rNeg_q ? -rem_q : rem_q;
                    lo_d   = divZero_q ? '1 : (qNeg_q ? -opA_q : opA_q);
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register. Reset clears everything, so HI/LO read zero and no
    // operation survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            qNeg_q    <= 1'b0;
            rNeg_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
            qNeg_q    <= qNeg_d;
            rNeg_q    <= rNeg_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo. Directed operations push their expected
// HI/LO pair; a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    muldiv_hilo_if #(.WIDTH(W)) bus();

    muldiv_hilo #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } expect_t;

    expect_t scoreboard[$];
    int checkCount = 0;
    int passCount  = 0;

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends, even if the DUT wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            passCount++;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        else
            passCount++;
    endtask

    // Whenever the unit reports completion, the oldest pending expectation must match.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_done: done=1 with nothing pending (hi=0x%08h lo=0x%08h) expected done=0",
                         bus.hi, bus.lo);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput({e.tag, " hi"}, bus.hi, e.hi);
                checkOutput({e.tag, " lo"}, bus.lo, e.lo);
            end
        end
    end

    task automatic idleInputs();
        bus.req_valid = 1'b0;
        bus.func      = '0;
        bus.A         = '0;
        bus.B         = '0;
        bus.alu_res   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [FUNC_W-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] alu, input logic fl);
        bus.req_valid = 1'b1;
        bus.func      = f;
        bus.A         = a;
        bus.B         = b;
        bus.alu_res   = alu;
        bus.flush     = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issues a mul/div in the current cycle (cycle 0). It checks busy/done in
    // every cycle up to the completion cycle and returns at that cycle's negedge.
    task automatic runOp(input string tag, input logic [FUNC_W-1:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int latency,
                         input logic [W-1:0] expHi, input logic [W-1:0] expLo);
        scoreboard.push_back('{tag, expHi, expLo});
        applyStimulus(f, a, b, '0, 1'b0);
        for (int c = 1; c <= latency; c++) begin
            nextCycle();
            if (c == 1) idleInputs();
            @(negedge clk);
            checkBit($sformatf("%s busy c%0d", tag, c), bus.busy, c < latency);
            checkBit($sformatf("%s done c%0d", tag, c), bus.done, c == latency);
        end
    endtask

    // Directed sequence; each next op is accepted in the done cycle of the previous.
    initial begin
        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi", bus.hi, '0);
        checkOutput("reset lo", bus.lo, '0);
        checkBit("reset busy", bus.busy, 1'b0);
        checkBit("reset done", bus.done, 1'b0);
        rst = 1'b0;
        nextCycle();

        runOp("mult",         FUNC_MULT,  32'hFFFF_FFFF, 32'd2,         2,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("multu",        FUNC_MULTU, 32'hFFFF_FFFF, 32'd2,         2,  32'h0000_0001, 32'hFFFF_FFFE);
        runOp("div_neg",      FUNC_DIV,   32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu",         FUNC_DIVU,  32'hFFFF_FFF9, 32'd2,         34, 32'h0000_0001, 32'h7FFF_FFFC);
        runOp("div_zero",     FUNC_DIV,   32'd5,         32'd0,         34, 32'h0000_0005, 32'hFFFF_FFFF);
        runOp("div_neg_zero", FUNC_DIV,   32'hFFFF_FFF9, 32'd0,         34, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        runOp("div_overflow", FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
        runOp("div_pos_neg",  FUNC_DIV,   32'd100,       32'hFFFF_FFF9, 34, 32'h0000_0002, 32'hFFFF_FFF2);

        applyStimulus(FUNC_MTHI, '0, '0, 32'h1234, 1'b0);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("mthi hi", bus.hi, 32'h1234);
        checkBit("mthi done", bus.done, 1'b0);
        checkBit("mthi busy", bus.busy, 1'b0);

        applyStimulus(FUNC_MTHI, '0, '0, 32'h11, 1'b0);
        nextCycle();
        applyStimulus(FUNC_MTLO, '0, '0, 32'h22, 1'b0);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("preload hi", bus.hi, 32'h11);
        checkOutput("preload lo", bus.lo, 32'h22);

        // DIV that gets an ignored MTLO in cycle 5 and a flush in cycle 10.
        applyStimulus(FUNC_DIV, 32'd100, 32'd7, '0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            nextCycle();
            idleInputs();
            if (c == 5) applyStimulus(FUNC_MTLO, '0, '0, 32'h99, 1'b0);
            if (c == 10) bus.flush = 1'b1;
            @(negedge clk);
            checkBit($sformatf("flush busy c%0d", c), bus.busy, c <= 10);
        end
        checkOutput("flush hi kept", bus.hi, 32'h11);
        checkOutput("flush lo kept", bus.lo, 32'h22);
        for (int c = 12; c <= 36; c++) begin
            nextCycle();
            @(negedge clk);
            checkBit($sformatf("flush no done c%0d", c), bus.done, 1'b0);
        end

        // MULT presented together with flush must not be accepted.
        applyStimulus(FUNC_MULT, 32'd3, 32'd4, '0, 1'b1);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkBit("mult+flush busy", bus.busy, 1'b0);
        nextCycle();
        @(negedge clk);
        checkBit("mult+flush done", bus.done, 1'b0);
        checkOutput("mult+flush hi", bus.hi, 32'h11);
        checkOutput("mult+flush lo", bus.lo, 32'h22);

        // Asynchronous reset in the middle of a divide, away from any clock edge.
        applyStimulus(FUNC_DIV, 32'd100, 32'd7, '0, 1'b0);
        nextCycle();
        idleInputs();
        repeat (4) nextCycle();
        checkBit("pre-reset busy", bus.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkBit("async reset busy", bus.busy, 1'b0);
        checkBit("async reset done", bus.done, 1'b0);
        checkOutput("async reset hi", bus.hi, '0);
        checkOutput("async reset lo", bus.lo, '0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        runOp("mult_after_reset", FUNC_MULT, 32'd3, 32'd4, 2, 32'd0, 32'd12);
        nextCycle();
        @(negedge clk);
        checkOutput("scoreboard drained", W'(scoreboard.size()), '0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
